// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_pkg                                              |
// | Description : Shared types for the CPU/DMA memory arbiter.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DMA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                               |
// | Description : CPU/DMA request ports and memory bus of the arbiter.         |
// |               dma_lock exists only when MEM_ARB_LOCK_EN is defined.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic              dma_lock;
`endif

    // Arbiter side
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  dma_lock,
`endif
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_addr, mem_wdata, mem_write,
        input  mem_rdata
    );

    // Requesters and memory side
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output dma_lock,
`endif
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_addr, mem_wdata, mem_write,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_rd_pipe                                          |
// | Description : Shift register carrying {valid,owner} read tags to the       |
// |               cycle their memory data is ready.                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter_rd_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    input  rd_tag_t      i_tag,
    output rd_tag_t      o_tag
);
    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Sticky-owner CPU/DMA arbiter with burst cap for a single     |
// |               synchronous memory. Define MEM_ARB_LOCK_EN for dma_lock.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int MEM_LAT   = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.slave  bus
);
    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    arb_state_t         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               w_cpu_gnt, w_dma_gnt, w_lock, w_cap, w_owner_hs, w_other_req;
    rd_tag_t            w_tag_in, w_tag_ret;

    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata, r_cpu_rdata, r_dma_rdata;
    logic               r_mem_write, r_cpu_rvalid, r_dma_rvalid;

`ifdef MEM_ARB_LOCK_EN
    assign w_lock = bus.dma_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_cap = (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_hs  = 1'b0;
        w_other_req = (r_state == S_DMA) ? bus.cpu_req : bus.dma_req;
        if (!reset) begin
            // The loader lock hands every cycle to DMA regardless of the burst count
            if (w_lock) begin
                w_dma_gnt = bus.dma_req;
            end else begin
                case (r_state)
                    S_CPU: begin
                        if (bus.cpu_req && !(bus.dma_req && w_cap)) w_cpu_gnt = 1'b1;
                        else                                        w_dma_gnt = bus.dma_req;
                    end
                    S_DMA: begin
                        if (bus.dma_req && !(bus.cpu_req && w_cap)) w_dma_gnt = 1'b1;
                        else                                        w_cpu_gnt = bus.cpu_req;
                    end
                    default: begin
                        w_cpu_gnt = bus.cpu_req;
                        w_dma_gnt = !bus.cpu_req && bus.dma_req;
                    end
                endcase
            end
        end
        w_owner_hs = (r_state == S_CPU && w_cpu_gnt) || (r_state == S_DMA && w_dma_gnt);

        if (w_cpu_gnt)                         w_state_nxt = S_CPU;
        else if (w_dma_gnt)                    w_state_nxt = S_DMA;
        else if (!bus.cpu_req && !bus.dma_req) w_state_nxt = S_IDLE;

        if ((w_cpu_gnt || w_dma_gnt) && !w_owner_hs)     w_cnt_nxt = '0;
        else if (r_state == S_IDLE || !w_other_req)      w_cnt_nxt = '0;
        else if (w_owner_hs && !w_cap)                   w_cnt_nxt = r_cnt + c_CNT_ONE;
    end

    assign w_tag_in.valid = (w_cpu_gnt && !bus.cpu_we) || (w_dma_gnt && !bus.dma_we);
    assign w_tag_in.owner = w_dma_gnt ? OWN_DMA : OWN_CPU;

    mem_arbiter_rd_pipe #(.DEPTH(MEM_LAT + 1)) u_rd_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_tag_in),
        .o_tag (w_tag_ret)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_write  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_mem_write  <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            if (w_cpu_gnt) begin
                r_mem_addr  <= bus.cpu_addr;
                r_mem_wdata <= bus.cpu_wdata;
                r_mem_write <= bus.cpu_we;
            end else if (w_dma_gnt) begin
                r_mem_addr  <= bus.dma_addr;
                r_mem_wdata <= bus.dma_wdata;
                r_mem_write <= bus.dma_we;
            end
            if (w_tag_ret.valid) begin
                if (w_tag_ret.owner == OWN_CPU) begin
                    r_cpu_rdata  <= bus.mem_rdata;
                    r_cpu_rvalid <= 1'b1;
                end else begin
                    r_dma_rdata  <= bus.mem_rdata;
                    r_dma_rvalid <= 1'b1;
                end
            end
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dma_gnt    = w_dma_gnt;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_write  = r_mem_write;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dma_rdata  = r_dma_rdata;
    assign bus.dma_rvalid = r_dma_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Directed + random bench for mem_arbiter with a queue-based   |
// |               reference model (MEM_ARB_LOCK_EN adds lock scenarios).       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
    localparam int ADDR_W = 8, DATA_W = 8, MAX_BURST = 4, MEM_LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic lock_now;
`ifdef MEM_ARB_LOCK_EN
    assign lock_now = bus.dma_lock;
`else
    assign lock_now = 1'b0;
`endif

    function automatic logic [7:0] init_byte(int i);
        return (i == 8'h10) ? 8'hAB : (8'(i) ^ 8'hC3);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Synchronous RAM behind the arbiter
    logic [7:0] ram [256];
    logic [7:0] rd_q [MEM_LAT];
    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
        else if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_q[0] <= ram[bus.mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_q[i] <= rd_q[i-1];
    end
    assign bus.mem_rdata = rd_q[MEM_LAT-1];

    // Reference model: owner 0=none 1=cpu 2=dma; pending reads carry the edge they return on
    typedef struct { int port; logic [7:0] data; int due; } rd_t;
    rd_t        pend [$];
    logic [7:0] shadow [256];
    int         m_owner, m_cnt, edge_n;
    logic       model_valid = 1'b0, shadow_done = 1'b0;
    logic       e_mw, e_cv, e_dv;
    logic [7:0] e_ma, e_md, e_cd, e_dd;

    function automatic logic req_of(int p);
        return (p == 1) ? bus.cpu_req : (p == 2) ? bus.dma_req : 1'b0;
    endfunction

    always @(negedge clk) begin : p_model
        logic g_c, g_d, we;
        logic [7:0] a, d;
        int port;
        rd_t r;
        if (!shadow_done) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_byte(i);
            shadow_done = 1'b1;
        end
        g_c = 1'b0; g_d = 1'b0;
        if (!reset) begin
            if (lock_now) g_d = bus.dma_req;
            else if (m_owner == 0) begin
                g_c = bus.cpu_req;
                g_d = !bus.cpu_req && bus.dma_req;
            end else if (req_of(m_owner) && !(req_of(3 - m_owner) && m_cnt >= MAX_BURST)) begin
                if (m_owner == 1) g_c = 1'b1; else g_d = 1'b1;
            end else if (req_of(3 - m_owner)) begin
                if (m_owner == 1) g_d = 1'b1; else g_c = 1'b1;
            end
        end
        if (model_valid) begin
            check("gnt", {bus.cpu_gnt, bus.dma_gnt}, {g_c, g_d});
            check("mem_bus", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {e_mw, e_ma, e_md});
            check("cpu_ret", {bus.cpu_rvalid, bus.cpu_rdata}, {e_cv, e_cd});
            check("dma_ret", {bus.dma_rvalid, bus.dma_rdata}, {e_dv, e_dd});
        end
        edge_n++;
        if (reset) begin
            m_owner = 0; m_cnt = 0; pend.delete();
            {e_mw, e_ma, e_md, e_cv, e_cd, e_dv, e_dd} = '0;
            model_valid = 1'b1;
        end else begin
            e_cv = 1'b0; e_dv = 1'b0; e_mw = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                r = pend.pop_front();
                if (r.port == 1) begin e_cv = 1'b1; e_cd = r.data; end
                else             begin e_dv = 1'b1; e_dd = r.data; end
            end
            if (g_c || g_d) begin
                port = g_c ? 1 : 2;
                we   = g_c ? bus.cpu_we   : bus.dma_we;
                a    = g_c ? bus.cpu_addr : bus.dma_addr;
                d    = g_c ? bus.cpu_wdata : bus.dma_wdata;
                e_ma = a; e_md = d; e_mw = we;
                if (we) shadow[a] = d;
                else    pend.push_back('{port, shadow[a], edge_n + MEM_LAT + 1});
                if (port != m_owner || !req_of(3 - port)) m_cnt = 0;
                else if (m_cnt < MAX_BURST)               m_cnt = m_cnt + 1;
                m_owner = port;
            end else begin
                if (!bus.cpu_req && !bus.dma_req) m_owner = 0;
                if (m_owner == 0 || !req_of(3 - m_owner)) m_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(int n);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        repeat (n) tick();
    endtask

    initial begin : p_stim
        logic [11:0] cv, dv;
        logic hc, hd, rv;
        int cg, dg;
        {bus.cpu_req, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata} = '0;
        {bus.dma_req, bus.dma_we, bus.dma_addr, bus.dma_wdata} = '0;
`ifdef MEM_ARB_LOCK_EN
        bus.dma_lock = 1'b0;
`endif
        tick();
        mem_init = 1'b0;
        tick(); tick();
        check("reset_outputs", {bus.mem_write, bus.mem_addr, bus.cpu_rvalid, bus.dma_rvalid}, 0);
        reset = 1'b0;

        // Single CPU read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        #1 check("t1_gnt", bus.cpu_gnt, 1);
        tick();
        bus.cpu_req = 1'b0;
        check("t1_mem_addr", {bus.mem_write, bus.mem_addr}, 9'h010);
        tick();
        check("t1_no_early_rvalid", bus.cpu_rvalid, 0);
        tick();
        check("t1_rdata", {bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid}, {1'b1, 8'hAB, 1'b0});
        tick();
        check("t1_hold", {bus.cpu_rvalid, bus.cpu_rdata}, {1'b0, 8'hAB});

        // Simultaneous requests from idle
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h01;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h02;
        #1 check("t2_cpu_first", {bus.cpu_gnt, bus.dma_gnt}, 2'b10);
        tick();
        bus.cpu_req = 1'b0;
        #1 check("t2_dma_next", {bus.cpu_gnt, bus.dma_gnt}, 2'b01);
        tick();
        bus.dma_req = 1'b0;
        tick();
        check("t2_cpu_ret", {bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid}, {1'b1, 8'hC2, 1'b0});
        tick();
        check("t2_dma_ret", {bus.dma_rvalid, bus.dma_rdata, bus.cpu_rvalid}, {1'b1, 8'hC1, 1'b0});
        idle_n(2);

        // DMA stream with a waiting CPU: burst cap of four
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20;
        bus.cpu_we = 1'b0; bus.cpu_addr = 8'h40;
        for (int i = 0; i < 12; i++) begin
            if (i == 1 || i == 7) bus.cpu_req = 1'b1;
            #1;
            cv[i] = bus.cpu_gnt;
            dv[i] = bus.dma_gnt;
            tick();
            if (dv[i]) bus.dma_addr = bus.dma_addr + 8'd1;
            if (cv[i]) bus.cpu_req = 1'b0;
        end
        check("t3_cpu_grants", cv, 12'h820);
        check("t3_dma_grants", dv, 12'h7DF);
        idle_n(4);

        // DMA write
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h96; bus.dma_wdata = 8'h5A;
        #1 check("t4_gnt", bus.dma_gnt, 1);
        tick();
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        check("t4_write", {bus.mem_write, bus.mem_addr, bus.mem_wdata}, {1'b1, 8'h96, 8'h5A});
        rv = 1'b0;
        tick();
        check("t4_write_once", bus.mem_write, 0);
        for (int i = 0; i < 3; i++) begin
            rv = rv | bus.cpu_rvalid | bus.dma_rvalid;
            tick();
        end
        check("t4_no_rvalid", rv, 0);

        // Reset right after a CPU read handshake drops the read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
        tick();
        bus.cpu_req = 1'b0;
        reset = 1'b1;
        tick();
        check("t5_cleared", {bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.cpu_rvalid,
                             bus.cpu_rdata, bus.dma_rvalid, bus.dma_rdata}, 0);
        bus.cpu_req = 1'b1;
        #1 check("t5_gnt_in_reset", {bus.cpu_gnt, bus.dma_gnt}, 0);
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        check("t5_read_dropped", bus.cpu_rvalid, 0);
        tick();

`ifdef MEM_ARB_LOCK_EN
        bus.dma_lock = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 8'h50;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h60;
        cg = 0; dg = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            hd = bus.dma_gnt;
            cg += int'(bus.cpu_gnt);
            dg += int'(bus.dma_gnt);
            tick();
            if (hd) bus.dma_addr = bus.dma_addr + 8'd1;
        end
        check("t6_cpu_stalled", cg, 0);
        check("t6_dma_grants", dg, 10);
        bus.dma_lock = 1'b0;
        bus.dma_req = 1'b0;
        #1 check("t6_cpu_after_unlock", bus.cpu_gnt, 1);
        tick();
        bus.cpu_req = 1'b0;
        tick();
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            #1;
            hc = bus.cpu_req && bus.cpu_gnt;
            hd = bus.dma_req && bus.dma_gnt;
            tick();
            if (!bus.cpu_req || hc) begin
                bus.cpu_req   = ($urandom_range(0, 9) < 6);
                bus.cpu_we    = $urandom_range(0, 2) == 0;
                bus.cpu_addr  = 8'($urandom_range(0, 15));
                bus.cpu_wdata = 8'($urandom);
            end
            if (!bus.dma_req || hd) begin
                bus.dma_req   = ($urandom_range(0, 9) < 7);
                bus.dma_we    = $urandom_range(0, 2) == 0;
                bus.dma_addr  = 8'($urandom_range(0, 15));
                bus.dma_wdata = 8'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
`ifdef MEM_ARB_LOCK_EN
            if ($urandom_range(0, 39) == 0) bus.dma_lock = ~bus.dma_lock;
`endif
        end
        reset = 1'b0;
        idle_n(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
